// File: rtl/smvm_stream_tx.sv
// rtl/smvm_stream_tx.sv - SMVM job buffer and gap-free frame transmitter
module smvm_stream_tx #(
    parameter int K          = 4,
    parameter int MAX_COLS   = 256,
    parameter int NNZ_DEPTH  = 64,
    parameter int GAP_CYCLES = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cfg_rows,
    input  logic [7:0] cfg_cols,
    input  logic       vec_valid,
    output logic       vec_ready,
    input  logic [7:0] vec_data,
    input  logic       nz_valid,
    output logic       nz_ready,
    input  logic [7:0] nz_val,
    input  logic [7:0] nz_col,
    input  logic       nz_ipv,
    input  logic       nz_last,
    output logic [7:0] tx_val,
    output logic       tx_ipv,
    output logic       tx_valid,
    output logic       busy,
    output logic       frame_done,
    output logic       err_overflow
);
    localparam int VA_W = $clog2(MAX_COLS);
    localparam int NA_W = $clog2(NNZ_DEPTH);
    localparam int NC_W = NA_W + 1;
    localparam int GC_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_VEC, LOAD_NZ, S_ROWS, S_COLS, S_VEC, S_VAL, S_IDX, S_END, GAP
    } state_t;

    state_t            state;
    logic [7:0]        rows_q;
    logic [7:0]        cols_q;
    logic [7:0]        vec_cnt;
    logic [NC_W-1:0]   nz_cnt;
    logic [NC_W-1:0]   pidx;
    logic [NC_W-1:0]   pidx_inc;
    logic [NC_W-1:0]   nz_rem;
    logic [NC_W-1:0]   pair_total;
    logic [GC_W-1:0]   gap_cnt;
    logic              vec_hs;
    logic              nz_hs;
    logic [7:0]        cur_col;
    logic [7:0]        nxt_val;
    logic              nxt_ipv;

    logic [7:0] vec_mem [MAX_COLS];
    logic [7:0] val_mem [NNZ_DEPTH];
    logic [7:0] col_mem [NNZ_DEPTH];
    logic       ipv_mem [NNZ_DEPTH];

    assign vec_ready = (state == LOAD_VEC);
    assign nz_ready  = (state == LOAD_NZ) && (nz_cnt < NC_W'(NNZ_DEPTH));
    assign vec_hs    = vec_valid & vec_ready;
    assign nz_hs     = nz_valid & nz_ready;
    assign busy      = (state != IDLE);

    // Pair bookkeeping: padded pair count and the column/next value, zeroed past the stored entries
    always_comb begin
        pidx_inc   = pidx + 1'b1;
        nz_rem     = nz_cnt % NC_W'(K);
        pair_total = (nz_rem == '0) ? nz_cnt : nz_cnt + NC_W'(K) - nz_rem;
        cur_col    = (pidx < nz_cnt) ? col_mem[pidx[NA_W-1:0]] : 8'd0;
        nxt_val    = (pidx_inc < nz_cnt) ? val_mem[pidx_inc[NA_W-1:0]] : 8'd0;
        nxt_ipv    = (pidx_inc < nz_cnt) ? ipv_mem[pidx_inc[NA_W-1:0]] : 1'b0;
    end

    // Job buffers; contents are only meaningful up to the live counts, so no reset is needed
    always_ff @(posedge clk) begin
        if (vec_hs) begin
            vec_mem[vec_cnt[VA_W-1:0]] <= vec_data;
        end
        if (nz_hs) begin
            val_mem[nz_cnt[NA_W-1:0]] <= nz_val;
            col_mem[nz_cnt[NA_W-1:0]] <= nz_col;
            ipv_mem[nz_cnt[NA_W-1:0]] <= nz_ipv;
        end
    end

    // Main FSM; stream outputs are loaded on entry to each state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rows_q       <= '0;
            cols_q       <= '0;
            vec_cnt      <= '0;
            nz_cnt       <= '0;
            pidx         <= '0;
            gap_cnt      <= '0;
            tx_val       <= '0;
            tx_ipv       <= 1'b0;
            tx_valid     <= 1'b0;
            frame_done   <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rows_q       <= cfg_rows;
                        cols_q       <= cfg_cols;
                        err_overflow <= 1'b0;
                        vec_cnt      <= '0;
                        nz_cnt       <= '0;
                        pidx         <= '0;
                        state        <= (cfg_cols == 8'd0) ? LOAD_NZ : LOAD_VEC;
                    end
                end
                LOAD_VEC: begin
                    if (vec_hs) begin
                        if (vec_cnt == cols_q - 8'd1) begin
                            vec_cnt <= '0;
                            state   <= LOAD_NZ;
                        end else begin
                            vec_cnt <= vec_cnt + 8'd1;
                        end
                    end
                end
                LOAD_NZ: begin
                    if (nz_hs) begin
                        nz_cnt <= nz_cnt + 1'b1;
                        if (nz_last || nz_cnt == NC_W'(NNZ_DEPTH - 1)) begin
                            if (!nz_last) begin
                                err_overflow <= 1'b1;
                            end
                            state    <= S_ROWS;
                            tx_valid <= 1'b1;
                            tx_val   <= rows_q;
                            tx_ipv   <= 1'b0;
                        end
                    end
                end
                S_ROWS: begin
                    state  <= S_COLS;
                    tx_val <= cols_q;
                end
                S_COLS: begin
                    if (cols_q != 8'd0) begin
                        state   <= S_VEC;
                        tx_val  <= vec_mem[0];
                        vec_cnt <= 8'd1;
                    end else begin
                        state  <= S_VAL;
                        pidx   <= '0;
                        tx_val <= val_mem[0];
                        tx_ipv <= ipv_mem[0];
                    end
                end
                S_VEC: begin
                    if (vec_cnt == cols_q) begin
                        state  <= S_VAL;
                        pidx   <= '0;
                        tx_val <= val_mem[0];
                        tx_ipv <= ipv_mem[0];
                    end else begin
                        tx_val  <= vec_mem[vec_cnt[VA_W-1:0]];
                        vec_cnt <= vec_cnt + 8'd1;
                    end
                end
                S_VAL: begin
                    state  <= S_IDX;
                    tx_val <= cur_col;
                    tx_ipv <= 1'b0;
                end
                S_IDX: begin
                    if (pidx_inc == pair_total) begin
                        state    <= S_END;
                        tx_valid <= 1'b0;
                        tx_val   <= '0;
                        tx_ipv   <= 1'b0;
                    end else begin
                        state  <= S_VAL;
                        pidx   <= pidx_inc;
                        tx_val <= nxt_val;
                        tx_ipv <= nxt_ipv;
                    end
                end
                S_END: begin
                    state      <= GAP;
                    gap_cnt    <= GC_W'(1);
                    frame_done <= (GAP_CYCLES == 2);
                end
                GAP: begin
                    if (gap_cnt == GC_W'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt    <= gap_cnt + 1'b1;
                        frame_done <= (gap_cnt == GC_W'(GAP_CYCLES - 2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_smvm_stream_tx.sv
// tb/tb_smvm_stream_tx.sv - scoreboard bench for smvm_stream_tx
module tb_smvm_stream_tx;
    localparam int K   = 4;
    localparam int NNZ = 64;
    localparam int GAP = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] cfg_rows, cfg_cols;
    logic       vec_valid, vec_ready;
    logic [7:0] vec_data;
    logic       nz_valid, nz_ready;
    logic [7:0] nz_val, nz_col;
    logic       nz_ipv, nz_last;
    logic [7:0] tx_val;
    logic       tx_ipv, tx_valid, busy, frame_done, err_overflow;

    always #5 clk = ~clk;

    smvm_stream_tx dut (
        .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
        .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_val(nz_val), .nz_col(nz_col),
        .nz_ipv(nz_ipv), .nz_last(nz_last), .tx_val(tx_val), .tx_ipv(tx_ipv),
        .tx_valid(tx_valid), .busy(busy), .frame_done(frame_done), .err_overflow(err_overflow)
    );

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [8:0] exp_q [$];
    int         len_q [$];

    logic [7:0] jv [256];
    logic [7:0] jval [NNZ];
    logic [7:0] jcol [NNZ];
    logic       jipv [NNZ];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference frame: header, vector, entries padded to a multiple of K pairs
    task automatic push_expected(input int rows, input int cols, input int n);
        int t;
        t = ((n + K - 1) / K) * K;
        exp_q.push_back({1'b0, 8'(rows)});
        exp_q.push_back({1'b0, 8'(cols)});
        for (int i = 0; i < cols; i++) exp_q.push_back({1'b0, jv[i]});
        for (int i = 0; i < t; i++) begin
            if (i < n) begin
                exp_q.push_back({jipv[i], jval[i]});
                exp_q.push_back({1'b0, jcol[i]});
            end else begin
                exp_q.push_back(9'd0);
                exp_q.push_back(9'd0);
            end
        end
        len_q.push_back(2 + cols + 2 * t);
    endtask

    task automatic send_vec(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        vec_valid = 1'b1;
        vec_data  = b;
        for (int t = 0; t < 200 && !vec_ready; t++) @(negedge clk);
        check("vec_ready_wait", vec_ready, 1);
        @(negedge clk);
        vec_valid = 1'b0;
    endtask

    task automatic send_nz(input int i, input logic last);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        nz_valid = 1'b1;
        nz_val   = jval[i];
        nz_col   = jcol[i];
        nz_ipv   = jipv[i];
        nz_last  = last;
        for (int t = 0; t < 200 && !nz_ready; t++) @(negedge clk);
        check("nz_ready_wait", nz_ready, 1);
        @(negedge clk);
        nz_valid = 1'b0;
        nz_last  = 1'b0;
    endtask

    task automatic random_job(input int cols, input int n);
        for (int i = 0; i < cols; i++) jv[i] = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            jval[i] = 8'($urandom);
            jcol[i] = (cols == 0) ? 8'd0 : 8'($urandom % cols);
            jipv[i] = (i == 0) ? 1'b1 : 1'($urandom);
        end
    endtask

    // mode 0: normal, 1: start pulsed during vector phase, 2: reset mid value phase
    task automatic run_job(input int rows, input int cols, input int n, input logic give_last, input int mode);
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; cfg_rows = 8'(rows); cfg_cols = 8'(cols);
        @(negedge clk);
        start = 1'b0; cfg_rows = 8'd0; cfg_cols = 8'd0;
        push_expected(rows, cols, n);
        if (cols == 0) check("vec_ready_cols0", vec_ready, 0);
        for (int i = 0; i < cols; i++) send_vec(jv[i]);
        for (int i = 0; i < n; i++) send_nz(i, give_last && (i == n - 1));
        if (!give_last) begin
            check("nz_ready_full", nz_ready, 0);
            check("err_overflow_set", err_overflow, 1);
        end else begin
            check("err_overflow_clr", err_overflow, 0);
        end
        if (mode == 1) begin
            repeat (4) @(negedge clk);
            start = 1'b1; cfg_rows = 8'd99; cfg_cols = 8'd1;
            @(negedge clk);
            start = 1'b0;
        end
        if (mode == 2) begin
            repeat (8 + cols) @(negedge clk);
            rst = 1'b1;
            exp_q.delete();
            len_q.delete();
            @(negedge clk);
            check("rst_tx_valid", tx_valid, 0);
            check("rst_busy", busy, 0);
            rst = 1'b0;
        end else begin
            for (int t = 0; t < 3000 && done_cnt == d0; t++) @(negedge clk);
            check("frame_done_seen", int'(done_cnt > d0), 1);
            @(negedge clk);
            check("busy_after_frame", busy, 0);
        end
    endtask

    // Monitor: pops the scoreboard on every valid byte, checks frame length and gap timing
    initial begin
        int run;
        int low;
        logic in_gap;
        run = 0; low = 0; in_gap = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                run = 0; low = 0; in_gap = 1'b0;
            end else begin
                if (tx_valid) begin
                    if (exp_q.size() == 0) check("stream_unexpected", 1, 0);
                    else check("stream_byte", int'({tx_ipv, tx_val}), int'(exp_q.pop_front()));
                    run++;
                    low = 0;
                    in_gap = 1'b0;
                end else begin
                    if (run > 0) begin
                        if (len_q.size() == 0) check("frame_unexpected", run, 0);
                        else check("frame_len", run, len_q.pop_front());
                        run = 0;
                        in_gap = 1'b1;
                    end
                    if (in_gap) low++;
                end
                if (frame_done) begin
                    check("frame_done_gap", in_gap ? low : -1, GAP);
                    in_gap = 1'b0;
                    done_cnt++;
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; cfg_rows = 8'd0; cfg_cols = 8'd0;
        vec_valid = 1'b0; vec_data = 8'd0;
        nz_valid = 1'b0; nz_val = 8'd0; nz_col = 8'd0; nz_ipv = 1'b0; nz_last = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx_valid", tx_valid, 0);
        check("reset_tx_val", tx_val, 0);
        check("reset_busy", busy, 0);
        check("reset_vec_ready", vec_ready, 0);
        check("reset_nz_ready", nz_ready, 0);
        check("reset_err", err_overflow, 0);
        check("reset_done", frame_done, 0);
        rst = 1'b0;

        jv[0] = 8'd5; jv[1] = 8'd6; jv[2] = 8'd7;
        jval[0] = 8'd1; jcol[0] = 8'd0; jipv[0] = 1'b1;
        jval[1] = 8'd2; jcol[1] = 8'd2; jipv[1] = 1'b0;
        jval[2] = 8'd3; jcol[2] = 8'd1; jipv[2] = 1'b1;
        jval[3] = 8'd4; jcol[3] = 8'd2; jipv[3] = 1'b0;
        run_job(2, 3, 4, 1'b1, 0);

        jval[4] = 8'd8; jcol[4] = 8'd1; jipv[4] = 1'b1;
        run_job(2, 3, 5, 1'b1, 0);

        jval[0] = 8'd9; jcol[0] = 8'd0; jipv[0] = 1'b1;
        run_job(1, 0, 1, 1'b1, 0);

        random_job(10, NNZ);
        run_job(7, 10, NNZ, 1'b0, 0);

        random_job(20, 6);
        run_job(3, 20, 6, 1'b1, 1);

        random_job(4, 20);
        run_job(5, 4, 20, 1'b1, 2);
        random_job(5, 7);
        run_job(6, 5, 7, 1'b1, 0);

        for (int j = 0; j < 8; j++) begin
            int c;
            int n;
            c = $urandom_range(0, 30);
            n = $urandom_range(1, NNZ);
            random_job(c, n);
            run_job($urandom_range(0, 255), c, n, 1'b1, 0);
        end

        random_job(255, 3);
        run_job(255, 255, 3, 1'b1, 0);

        repeat (20) @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 0);
        check("len_queue_empty", len_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
